// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and
// the helper that tells multi-cycle operations apart from single-cycle ones.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_MOD = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_iter(alu_op_t op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_exec_unit_if.sv
// Request/response bundle between the operand front end and the ALU.
// The master side issues operations and consumes results; the slave is the ALU.
interface alu_seq_exec_unit_if #(parameter int N = 4);
  import alu_pkg::*;

  logic           req_valid_i;
  logic           req_ready_o;
  logic [N-1:0]   a_i;
  logic [N-1:0]   b_i;
  alu_op_t        op_i;
  logic           rsp_valid_o;
  logic           rsp_ready_i;
  logic [2*N-1:0] res_o;
  logic           carry_o;
  logic           zero_o;
  logic           div0_o;

  modport master (
    output req_valid_i, a_i, b_i, op_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, res_o, carry_o, zero_o, div0_o
  );

  modport slave (
    input  req_valid_i, a_i, b_i, op_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, res_o, carry_o, zero_o, div0_o
  );

endinterface

// File: rtl/alu_seq_divider.sv
// Restoring divider datapath: one quotient bit per enabled cycle, MSB first.
// quotient/remainder already include the step taken on the current enable.
module alu_seq_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  logic [N-1:0] quo_q;
  logic [N-1:0] rem_q;
  logic [N-1:0] div_q;
  logic [N:0]   shifted;
  logic [N:0]   diff;

  // Bit N of the trial difference is the borrow that decides whether to restore.
  always_comb begin
    shifted   = {rem_q, quo_q[N-1]};
    diff      = shifted - {1'b0, div_q};
    quotient  = quo_q;
    remainder = rem_q;
    if (en) begin
      if (!diff[N]) begin
        remainder = diff[N-1:0];
        quotient  = {quo_q[N-2:0], 1'b1};
      end else begin
        remainder = shifted[N-1:0];
        quotient  = {quo_q[N-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      div_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      div_q <= divisor;
    end else if (en) begin
      quo_q <= quotient;
      rem_q <= remainder;
    end
  end

endmodule

// File: rtl/alu_seq_exec_unit.sv
// Sequential ALU responder: single-cycle logic/add/sub, iterative MUL/DIV/MOD,
// one outstanding request with valid/ready handshakes on both sides.
module alu_seq_exec_unit
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_seq_exec_unit_if.slave bus
);

  localparam int CW = $clog2(N);

  state_t         state;
  state_t         state_next;
  logic           accept;
  logic           step;
  logic           finish;
  logic           go_iter;
  logic [CW-1:0]  cnt;
  alu_op_t        op_q;
  logic [N-1:0]   a_q;
  logic [2*N-1:0] prod;
  logic [2*N-1:0] prod_step;
  logic [N:0]     mul_sum;
  logic [2*N-1:0] res_q;
  logic           carry_q;
  logic           zero_q;
  logic           div0_q;
  logic [2*N-1:0] res_fast;
  logic           carry_fast;
  logic           div0_fast;
  logic [N:0]     sum_ext;
  logic [2*N-1:0] res_iter;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;

  assign bus.req_ready_o = (state == IDLE);
  assign bus.rsp_valid_o = (state == DONE);
  assign bus.res_o       = res_q;
  assign bus.carry_o     = carry_q;
  assign bus.zero_o      = zero_q;
  assign bus.div0_o      = div0_q;

  // Division by zero has a fixed answer, so it bypasses the iteration entirely.
  assign go_iter = is_iter(bus.op_i) &&
                   !(((bus.op_i == OP_DIV) || (bus.op_i == OP_MOD)) && (bus.b_i == '0));

  always_comb begin
    res_fast   = '0;
    carry_fast = 1'b0;
    div0_fast  = 1'b0;
    sum_ext    = '0;
    case (bus.op_i)
      OP_ADD: begin
        sum_ext    = {1'b0, bus.a_i} + {1'b0, bus.b_i};
        res_fast   = {{N{1'b0}}, sum_ext[N-1:0]};
        carry_fast = sum_ext[N];
      end
      OP_SUB: begin
        sum_ext    = {1'b0, bus.a_i} - {1'b0, bus.b_i};
        res_fast   = {{N{1'b0}}, sum_ext[N-1:0]};
        carry_fast = sum_ext[N];
      end
      OP_DIV: begin
        res_fast  = {{N{1'b0}}, {N{1'b1}}};
        div0_fast = 1'b1;
      end
      OP_MOD: begin
        res_fast  = {{N{1'b0}}, bus.a_i};
        div0_fast = 1'b1;
      end
      OP_AND:  res_fast = {{N{1'b0}}, bus.a_i & bus.b_i};
      OP_OR:   res_fast = {{N{1'b0}}, bus.a_i | bus.b_i};
      OP_XOR:  res_fast = {{N{1'b0}}, bus.a_i ^ bus.b_i};
      default: res_fast = '0;
    endcase
  end

  // Shift-add multiply: the multiplier sits in the low half and shifts out LSB first.
  always_comb begin
    mul_sum   = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, a_q} : '0);
    prod_step = {mul_sum, prod[N-1:1]};
    if (op_q == OP_DIV)
      res_iter = {{N{1'b0}}, quotient};
    else if (op_q == OP_MOD)
      res_iter = {{N{1'b0}}, remainder};
    else
      res_iter = prod_step;
  end

  alu_seq_divider #(.N(N)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .en        (step),
    .dividend  (bus.a_i),
    .divisor   (bus.b_i),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid_i) begin
          accept     = 1'b1;
          state_next = go_iter ? ITER : DONE;
        end
      end
      ITER: begin
        step = 1'b1;
        if (cnt == '0) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers change only on a direct accept or on the final iteration step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      prod    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else if (accept) begin
      op_q <= bus.op_i;
      a_q  <= bus.a_i;
      prod <= {{N{1'b0}}, bus.b_i};
      cnt  <= CW'(N - 1);
      if (!go_iter) begin
        res_q   <= res_fast;
        carry_q <= carry_fast;
        div0_q  <= div0_fast;
        zero_q  <= (res_fast == '0);
      end
    end else if (step) begin
      prod <= prod_step;
      if (cnt != '0) cnt <= cnt - CW'(1);
      if (finish) begin
        res_q   <= res_iter;
        carry_q <= 1'b0;
        div0_q  <= 1'b0;
        zero_q  <= (res_iter == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_exec_unit.sv
// Directed bench for alu_seq_exec_unit (N=4) with hand-computed expected results,
// covering handshakes, iteration latency, backpressure and mid-operation reset.
module tb_alu_seq_exec_unit;
  import alu_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   latency;
  logic ready_seen;

  alu_seq_exec_unit_if #(.N(N)) bus ();

  alu_seq_exec_unit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkResult(input string tag, input logic [7:0] res, input logic carry,
                             input logic zero, input logic div0);
    checkOutput({tag, ".res"},   16'(bus.res_o),   16'(res));
    checkOutput({tag, ".carry"}, 16'(bus.carry_o), 16'(carry));
    checkOutput({tag, ".zero"},  16'(bus.zero_o),  16'(zero));
    checkOutput({tag, ".div0"},  16'(bus.div0_o),  16'(div0));
  endtask

  // Issue one request, then scramble the inputs to prove they were captured;
  // latency counts the accept cycle as cycle 1.
  task automatic applyStimulus(input alu_op_t op, input logic [3:0] a, input logic [3:0] b,
                               output int lat, output logic rdy_seen);
    @(negedge clk);
    bus.op_i        = op;
    bus.a_i         = a;
    bus.b_i         = b;
    bus.req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    bus.a_i         = ~a;
    bus.b_i         = ~b;
    bus.op_i        = OP_XOR;
    lat      = 1;
    rdy_seen = 1'b0;
    while (!bus.rsp_valid_o && lat < 40) begin
      if (bus.req_ready_o) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic releaseResult(input string tag);
    @(negedge clk);
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready_i = 1'b0;
    checkOutput({tag, ".rel_valid"}, 16'(bus.rsp_valid_o), 16'd0);
    checkOutput({tag, ".rel_ready"}, 16'(bus.req_ready_o), 16'd1);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.op_i        = OP_ADD;
    #12;
    checkOutput("reset.ready", 16'(bus.req_ready_o), 16'd1);
    checkOutput("reset.valid", 16'(bus.rsp_valid_o), 16'd0);
    checkResult("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(OP_ADD, 4'b1111, 4'b1000, latency, ready_seen);
    checkOutput("add.latency", 16'(latency), 16'd1);
    checkResult("add", 8'h07, 1'b1, 1'b0, 1'b0);
    releaseResult("add");

    applyStimulus(OP_SUB, 4'b1111, 4'b1111, latency, ready_seen);
    checkResult("sub_eq", 8'h00, 1'b0, 1'b1, 1'b0);
    releaseResult("sub_eq");

    applyStimulus(OP_SUB, 4'b0010, 4'b0101, latency, ready_seen);
    checkResult("sub_borrow", 8'h0D, 1'b1, 1'b0, 1'b0);
    releaseResult("sub_borrow");

    applyStimulus(OP_MUL, 4'b1111, 4'b1111, latency, ready_seen);
    checkOutput("mul.latency", 16'(latency), 16'd5);
    checkOutput("mul.ready_seen", 16'(ready_seen), 16'd0);
    checkOutput("mul.ready_done", 16'(bus.req_ready_o), 16'd0);
    checkResult("mul", 8'hE1, 1'b0, 1'b0, 1'b0);
    releaseResult("mul");

    applyStimulus(OP_MUL, 4'b0110, 4'b0101, latency, ready_seen);
    checkResult("mul_6x5", 8'h1E, 1'b0, 1'b0, 1'b0);
    releaseResult("mul_6x5");

    applyStimulus(OP_DIV, 4'b1010, 4'b0011, latency, ready_seen);
    checkOutput("div.latency", 16'(latency), 16'd5);
    checkResult("div", 8'h03, 1'b0, 1'b0, 1'b0);
    releaseResult("div");

    applyStimulus(OP_MOD, 4'b1010, 4'b0011, latency, ready_seen);
    checkResult("mod", 8'h01, 1'b0, 1'b0, 1'b0);
    releaseResult("mod");

    applyStimulus(OP_DIV, 4'b1001, 4'b0000, latency, ready_seen);
    checkOutput("div0.latency", 16'(latency), 16'd1);
    checkResult("div0", 8'h0F, 1'b0, 1'b0, 1'b1);
    releaseResult("div0");

    applyStimulus(OP_MOD, 4'b1001, 4'b0000, latency, ready_seen);
    checkResult("mod0", 8'h09, 1'b0, 1'b0, 1'b1);
    releaseResult("mod0");

    applyStimulus(OP_OR, 4'b1100, 4'b0011, latency, ready_seen);
    checkResult("or", 8'h0F, 1'b0, 1'b0, 1'b0);
    releaseResult("or");

    // Backpressure with a stray request pulse while the result is held.
    applyStimulus(OP_XOR, 4'b1100, 4'b0101, latency, ready_seen);
    checkResult("xor", 8'h09, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold.res",   16'(bus.res_o),       16'h09);
      checkOutput("hold.valid", 16'(bus.rsp_valid_o), 16'd1);
      checkOutput("hold.ready", 16'(bus.req_ready_o), 16'd0);
      if (i == 3) begin
        bus.op_i        = OP_ADD;
        bus.a_i         = 4'b0001;
        bus.b_i         = 4'b0001;
        bus.req_valid_i = 1'b1;
      end else begin
        bus.req_valid_i = 1'b0;
      end
    end
    checkResult("hold_end", 8'h09, 1'b0, 1'b0, 1'b0);

    // Release and new request in the same DONE cycle: accepted one cycle later.
    @(negedge clk);
    bus.rsp_ready_i = 1'b1;
    bus.op_i        = OP_ADD;
    bus.a_i         = 4'b0011;
    bus.b_i         = 4'b0100;
    bus.req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready_i = 1'b0;
    checkOutput("simul.ready", 16'(bus.req_ready_o), 16'd1);
    checkOutput("simul.valid", 16'(bus.rsp_valid_o), 16'd0);
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    checkOutput("simul.accept_valid", 16'(bus.rsp_valid_o), 16'd1);
    checkResult("simul", 8'h07, 1'b0, 1'b0, 1'b0);
    releaseResult("simul");

    // Reset during the second ITER cycle of a multiply.
    @(negedge clk);
    bus.op_i        = OP_MUL;
    bus.a_i         = 4'b1111;
    bus.b_i         = 4'b1111;
    bus.req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.ready", 16'(bus.req_ready_o), 16'd1);
    checkOutput("midrst.valid", 16'(bus.rsp_valid_o), 16'd0);
    checkResult("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(OP_AND, 4'b1100, 4'b1010, latency, ready_seen);
    checkOutput("and.latency", 16'(latency), 16'd1);
    checkResult("and", 8'h08, 1'b0, 1'b0, 1'b0);
    releaseResult("and");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
